// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned SERIAL_SUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sub_state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: diff = a - b, borrow set when b exceeds a.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one borrow flop; result every WIDTH+2 cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 low result bits; the final bit joins them on the last edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             accept;
  logic             hs0_diff, hs0_borrow;
  logic             slice_diff, hs1_borrow;
  logic             slice_bout;
  logic [WIDTH-1:0] res_full;

  half_subtractor u_hs0 (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .diff   (hs0_diff),
    .borrow (hs0_borrow)
  );

  half_subtractor u_hs1 (
    .a      (hs0_diff),
    .b      (bin_q),
    .diff   (slice_diff),
    .borrow (hs1_borrow)
  );

  assign slice_bout = hs0_borrow | hs1_borrow;
  assign res_full   = {slice_diff, res_q};

  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q == StRun) || (state_q == StDone);
  assign done        = (state_q == StDone);
  assign accept      = start_valid && start_ready;
  assign diff        = diff_q;
  assign borrow      = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_sign_q, a_sign_d;
  logic b_sign_q, b_sign_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_sign_d = a[WIDTH-1];
      b_sign_d = b[WIDTH-1];
    end else if ((state_q == StRun) && (cnt_q == LastCnt)) begin
      ovf_d = (a_sign_q != b_sign_q) && (slice_diff != a_sign_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          bin_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d  = res_full[WIDTH-1:1];
        bin_d  = slice_bout;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          diff_d   = res_full;
          borrow_d = slice_bout;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks for serial_subtractor at WIDTH = 8.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] diff;
  logic       borrow;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .diff        (diff),
    .borrow      (borrow),
    .busy        (busy),
    .done        (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 2 ms");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_diff(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    r = x - y;
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    r = x - y;
    return (x[7] != y[7]) && (r[7] != x[7]);
  endfunction

  logic cur_ovf;
  always_comb begin
    cur_ovf = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    cur_ovf = ovf;
`endif
  end

  // Full transaction from an idle DUT, checking latency, pulse width and results.
  task automatic run_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    @(negedge clk);
    check_eq({tag, "_ready"}, start_ready, 1'b1);
    a = xa;
    b = xb;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    check_eq({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 8);
    check_eq({tag, "_diff"}, diff, ed);
    check_eq({tag, "_borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
    check_eq({tag, "_ovf"}, ovf, eo);
`else
    if (eo) begin end
`endif
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, done, 1'b0);
    check_eq({tag, "_idle_ready"}, start_ready, 1'b1);
  endtask

  logic [15:0] pend_q[$];

  initial begin
    int last_acc;
    int n_acc;
    int n_done;
    logic [15:0] ent;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    #23;
    check_eq("rst_ready", start_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_diff", diff, 8'h00);
    check_eq("rst_borrow", borrow, 1'b0);
    check_eq("rst_ovf", cur_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    run_op("t2a", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    run_op("t2b", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op("t3a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("t3b", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op("t3c", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);
    run_op("zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("ff_1", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
    run_op("eq", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
    run_op("pre_rst", 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);

    // Reset after four bits of FF - 01; prior results must be wiped.
    @(negedge clk);
    a = 8'hFF;
    b = 8'h01;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_diff", diff, 8'h00);
    check_eq("mid_rst_borrow", borrow, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_ready", start_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check_eq("mid_rst_no_done", n_done, 0);
    check_eq("mid_rst_diff_held", diff, 8'h00);
    check_eq("mid_rst_ready_after", start_ready, 1'b1);

    // start_valid held high with operands changing every cycle.
    last_acc = -1;
    n_acc = 0;
    n_done = 0;
    for (int cyc = 0; cyc < 42; cyc++) begin
      @(negedge clk);
      a = 8'(cyc * 37 + 5);
      b = 8'(cyc * 11 + 3);
      start_valid = 1'b1;
      if (start_ready) begin
        pend_q.push_back({a, b});
        if (last_acc >= 0) check_eq("accept_gap", cyc - last_acc, 10);
        last_acc = cyc;
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (pend_q.size() == 0) begin
          check_eq("hold_unexpected_done", 1, 0);
        end else begin
          ent = pend_q.pop_front();
          check_eq("hold_diff", diff, ref_diff(ent[15:8], ent[7:0]));
          check_eq("hold_borrow", borrow, ent[15:8] < ent[7:0]);
        end
      end
    end
    @(negedge clk);
    start_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done && pend_q.size() != 0) begin
        n_done++;
        ent = pend_q.pop_front();
        check_eq("hold_diff", diff, ref_diff(ent[15:8], ent[7:0]));
        check_eq("hold_borrow", borrow, ent[15:8] < ent[7:0]);
      end
    end
    check_eq("hold_accepts", n_acc, 5);
    check_eq("hold_dones", n_done, n_acc);

    // Strided sweep against the reference model.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [7:0] sa;
        logic [7:0] sb;
        sa = 8'(i * 17);
        sb = 8'(j * 17 + (i % 3));
        run_op("sweep", sa, sb, ref_diff(sa, sb), sa < sb, ref_ovf(sa, sb));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
